// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// A round-robin pointer breaks ties; operands and result are registered around the ALU.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_req_valid,
  output logic             s0_req_ready,
  input  logic [WIDTH-1:0] s0_a,
  input  logic [WIDTH-1:0] s0_b,
  input  logic [OPW-1:0]   s0_op,
  output logic             s0_rsp_valid,
  input  logic             s0_rsp_ready,
  output logic [WIDTH-1:0] s0_rsp_y,
  input  logic             s1_req_valid,
  output logic             s1_req_ready,
  input  logic [WIDTH-1:0] s1_a,
  input  logic [WIDTH-1:0] s1_b,
  input  logic [OPW-1:0]   s1_op,
  output logic             s1_rsp_valid,
  input  logic             s1_rsp_ready,
  output logic [WIDTH-1:0] s1_rsp_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             gnt_r;
  logic             ptr_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [OPW-1:0]   alu_op_r;
  logic [WIDTH-1:0] rsp_y_r;
  logic [1:0]       rsp_valid_r;
  logic             busy_r;

  logic             winner_s;
  logic             idle_s;
  logic             hs_s;
  logic             sel_rsp_ready_s;

  // Winner selection: a lone requester always wins, ptr breaks a tie.
  always_comb begin
    winner_s = ptr_r;
    if (s0_req_valid && s1_req_valid) begin
      winner_s = ptr_r;
    end else if (s0_req_valid) begin
      winner_s = 1'b0;
    end else if (s1_req_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = ptr_r;
    end
  end

  assign idle_s          = (state_r == IDLE);
  assign s0_req_ready    = idle_s && s0_req_valid && (winner_s == 1'b0);
  assign s1_req_ready    = idle_s && s1_req_valid && (winner_s == 1'b1);
  assign hs_s            = s0_req_ready || s1_req_ready;
  assign sel_rsp_ready_s = gnt_r ? s1_rsp_ready : s0_rsp_ready;

  // Arbitration FSM; busy and rsp_valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= 1'b0;
      ptr_r       <= 1'b0;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_op_r    <= '0;
      rsp_y_r     <= '0;
      rsp_valid_r <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            gnt_r    <= winner_s;
            alu_a_r  <= winner_s ? s1_a  : s0_a;
            alu_b_r  <= winner_s ? s1_b  : s0_b;
            alu_op_r <= winner_s ? s1_op : s0_op;
            state_r  <= EXEC;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= IDLE;
          end
        end
        EXEC: begin
          rsp_y_r     <= alu_y;
          rsp_valid_r <= gnt_r ? 2'b10 : 2'b01;
          state_r     <= RESP;
        end
        RESP: begin
          // Result and valid stay frozen until the granted port takes them.
          if (sel_rsp_ready_s) begin
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
            ptr_r       <= ~gnt_r;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_op       = alu_op_r;
  assign s0_rsp_valid = rsp_valid_r[0];
  assign s1_rsp_valid = rsp_valid_r[1];
  assign s0_rsp_y     = rsp_y_r;
  assign s1_rsp_y     = rsp_y_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small add/sub ALU model,
// followed by bounded random two-port traffic checked against a scoreboard.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] a_v [2];
  logic [31:0] b_v [2];
  logic [2:0]  op_v [2];

  logic        s0_req_ready, s1_req_ready, s0_rsp_valid, s1_rsp_valid, busy;
  logic [31:0] s0_rsp_y, s1_rsp_y, alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_y [2];

  int ncmp = 0;
  int nfail = 0;

  assign req_ready = {s1_req_ready, s0_req_ready};
  assign rsp_valid = {s1_rsp_valid, s0_rsp_valid};
  assign rsp_y[0]  = s0_rsp_y;
  assign rsp_y[1]  = s1_rsp_y;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    return (op == 3'b001) ? (a - b) : (a + b);
  endfunction

  assign alu_y = alu_model(alu_a, alu_b, alu_op);

  alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_req_valid(req_valid[0]), .s0_req_ready(s0_req_ready),
    .s0_a(a_v[0]), .s0_b(b_v[0]), .s0_op(op_v[0]),
    .s0_rsp_valid(s0_rsp_valid), .s0_rsp_ready(rsp_ready[0]), .s0_rsp_y(s0_rsp_y),
    .s1_req_valid(req_valid[1]), .s1_req_ready(s1_req_ready),
    .s1_a(a_v[1]), .s1_b(b_v[1]), .s1_op(op_v[1]),
    .s1_rsp_valid(s1_rsp_valid), .s1_rsp_ready(rsp_ready[1]), .s1_rsp_y(s1_rsp_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .busy(busy)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    a_v[k] = a;
    b_v[k] = b;
    op_v[k] = op;
    req_valid[k] = 1'b1;
  endtask

  initial begin
    logic [31:0] expv [2];
    logic [1:0]  outst;
    logic [1:0]  acc;
    int          waitc [2];
    int          cyc;
    int          done;
    int          j;

    for (int k = 0; k < 2; k++) begin
      a_v[k] = 32'h0;
      b_v[k] = 32'h0;
      op_v[k] = 3'b000;
    end

    // Reset state
    step(); step();
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_rspv", 32'(rsp_valid), 32'h0);
    chk32("rst_alu_a", alu_a, 32'h0);
    chk32("rst_alu_b", alu_b, 32'h0);
    chk32("rst_alu_op", 32'(alu_op), 32'h0);
    chk32("rst_rsp_y", s0_rsp_y, 32'h0);
    chk32("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    step();

    // Lone port 0: 1 + (-1) = 0, busy exactly two cycles
    set_req(0, 32'h1, 32'hFFFF_FFFF, 3'b000);
    #1;
    chk32("t1_ready", 32'(req_ready), 32'h1);
    step(); req_valid[0] = 1'b0; #1;
    chk1("t1_ready_drop", s0_req_ready, 1'b0);
    chk1("t1_busy_exec", busy, 1'b1);
    chk32("t1_alu_a", alu_a, 32'h1);
    chk32("t1_alu_b", alu_b, 32'hFFFF_FFFF);
    chk1("t1_rspv_exec", s0_rsp_valid, 1'b0);
    step();
    chk32("t1_rspv", 32'(rsp_valid), 32'h1);
    chk32("t1_y", s0_rsp_y, 32'h0);
    chk1("t1_busy_resp", busy, 1'b1);
    step();
    chk1("t1_busy_done", busy, 1'b0);
    chk32("t1_rspv_done", 32'(rsp_valid), 32'h0);

    // Reset to bring ptr back to 0, then a simultaneous pair
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    set_req(0, 32'd5, 32'd3, 3'b000);
    set_req(1, 32'd5, 32'd3, 3'b001);
    #1;
    chk32("t2_tie_ptr0", 32'(req_ready), 32'h1);
    step(); req_valid[0] = 1'b0; #1;
    chk32("t2_exec_ready", 32'(req_ready), 32'h0);
    chk32("t2_alu_op0", 32'(alu_op), 32'h0);
    step();
    chk32("t2_rspv0", 32'(rsp_valid), 32'h1);
    chk32("t2_y0", s0_rsp_y, 32'd8);
    set_req(0, 32'd7, 32'd2, 3'b001);
    #1;
    chk32("t2_resp_ready", 32'(req_ready), 32'h0);
    step();
    chk32("t2_tie_ptr1", 32'(req_ready), 32'h2);
    step(); req_valid[1] = 1'b0; #1;
    chk32("t2_alu_op1", 32'(alu_op), 32'h1);
    step();
    chk32("t2_rspv1", 32'(rsp_valid), 32'h2);
    chk32("t2_y1", s1_rsp_y, 32'd2);
    step();
    chk32("t2_s0_next", 32'(req_ready), 32'h1);
    step(); req_valid[0] = 1'b0;
    step();
    chk32("t2_rspv0b", 32'(rsp_valid), 32'h1);
    chk32("t2_y0b", s0_rsp_y, 32'd5);
    step();

    // Port 1 stalled on rsp_ready while port 0 waits
    rsp_ready[1] = 1'b0;
    set_req(1, 32'h7FFF_FFFF, 32'h1, 3'b000);
    #1;
    chk32("t3_ready1", 32'(req_ready), 32'h2);
    step(); req_valid[1] = 1'b0;
    step();
    chk32("t3_rspv", 32'(rsp_valid), 32'h2);
    chk32("t3_y", s1_rsp_y, 32'h8000_0000);
    set_req(0, 32'h1, 32'h1, 3'b000);
    for (int i = 0; i < 10; i++) begin
      step();
      chk32("t3_hold_v", 32'(rsp_valid), 32'h2);
      chk32("t3_hold_y", s1_rsp_y, 32'h8000_0000);
      chk1("t3_s0_blocked", s0_req_ready, 1'b0);
    end
    rsp_ready[1] = 1'b1;
    step();
    chk32("t3_s0_ready", 32'(req_ready), 32'h1);
    step(); req_valid[0] = 1'b0;
    step();
    chk32("t3_rspv0", 32'(rsp_valid), 32'h1);
    chk32("t3_y0", s0_rsp_y, 32'd2);
    step();

    // Asynchronous reset during EXEC discards the transaction
    set_req(0, 32'd9, 32'd9, 3'b001);
    step(); req_valid[0] = 1'b0; #1;
    chk1("t4_busy_exec", busy, 1'b1);
    chk32("t4_alu_a", alu_a, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk1("t4_busy_rst", busy, 1'b0);
    chk32("t4_alu_a_rst", alu_a, 32'h0);
    chk32("t4_alu_b_rst", alu_b, 32'h0);
    chk32("t4_alu_op_rst", 32'(alu_op), 32'h0);
    chk32("t4_rspv_rst", 32'(rsp_valid), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk32("t4_no_rsp", 32'(rsp_valid), 32'h0);
    set_req(0, 32'd3, 32'd4, 3'b000);
    #1;
    chk1("t4_fresh_ready", s0_req_ready, 1'b1);
    step(); req_valid[0] = 1'b0;
    step();
    chk32("t4_fresh_v", 32'(rsp_valid), 32'h1);
    chk32("t4_fresh_y", s0_rsp_y, 32'd7);
    step();

    // Random traffic with a per-port scoreboard
    outst = 2'b00;
    waitc[0] = 0;
    waitc[1] = 0;
    expv[0] = 32'h0;
    expv[1] = 32'h0;
    cyc = 0;
    done = 0;
    while (done < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      chk1("rnd_two_ready", &req_ready, 1'b0);
      chk1("rnd_two_rspv", &rsp_valid, 1'b0);
      acc = req_valid & req_ready;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          expv[k] = alu_model(a_v[k], b_v[k], op_v[k]);
          outst[k] = 1'b1;
          waitc[k] = 0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          chk1("rnd_outstanding", outst[k], 1'b1);
          chk32("rnd_y", rsp_y[k], expv[k]);
          outst[k] = 1'b0;
          done++;
          j = 1 - k;
          if (req_valid[j] && !outst[j]) begin
            waitc[j]++;
            chk1("rnd_wait_bound", waitc[j] <= 1, 1'b1);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) req_valid[k] = 1'b0;
        if (!req_valid[k] && !outst[k] && $urandom_range(0, 1) == 1) begin
          set_req(k, $urandom(), $urandom(), 3'($urandom_range(0, 1)));
        end
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
    end
    chk1("rnd_completed", done >= 1000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
